// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle expiry pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload from the last load value on expiry.
//
// state  | meaning
// IDLE   | stopped, count holds, en ignored
// RUN    | decrementing once per enabled edge, busy=1
// EXPIRE | single-cycle expiry, count=0, done=1
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_val;
    end
  end
`endif

  // load takes priority in every state; a zero load always parks in IDLE without done
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
      state_nxt = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        RUN: begin
          if (en) begin
            count_nxt = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              state_nxt = EXPIRE;
            end
          end
        end
        EXPIRE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload != '0) begin
            count_nxt = reload;
            state_nxt = RUN;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
`else
          count_nxt = '0;
          state_nxt = IDLE;
`endif
        end
        default: begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == EXPIRE);
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table, directed corner sequences, random vs reference model.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // reference model: remaining count, running/expired flags, remembered load value
  int m_cnt  = 0;
  bit m_run  = 0;
  bit m_exp  = 0;
  int m_rel  = 0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    bit         ld;
    logic [3:0] val;
    bit         e;
    logic [3:0] c;
    bit         b;
    bit         d;
  } vec_t;

  vec_t tbl[$];

  down_counter_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_run = 0;
    m_exp = 0;
    m_rel = 0;
  endtask

  task automatic model_step(input bit ld, input int val, input bit e);
    bit was_exp;
    was_exp = m_exp;
    m_exp = 0;
    if (ld) begin
      m_rel = val;
      m_cnt = val;
      m_run = (val != 0);
    end else if (m_run) begin
      if (e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_run = 0;
          m_exp = 1;
        end
      end
    end else if (was_exp && AUTO && m_rel != 0) begin
      m_cnt = m_rel;
      m_run = 1;
    end
  endtask

  // inputs change at the falling edge; outputs are sampled at the next falling edge
  task automatic tick(input bit ld, input logic [3:0] v, input bit e);
    load     = ld;
    load_val = v;
    en       = e;
    @(posedge clk);
    model_step(ld, int'(v), e);
    @(negedge clk);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".count"}, int'(count), m_cnt);
    chk({nm, ".busy"}, int'(busy), int'(m_run));
    chk({nm, ".done"}, int'(done), int'(m_exp));
  endtask

  initial begin
    int ndone;
    int seq_exp[8];

    rst_n = 1'b0;
    load = 1'b0;
    load_val = '0;
    en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.count", int'(count), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back('{0, 4'd0, 1, 4'd0, 0, 0});
    tbl.push_back('{1, 4'd0, 0, 4'd0, 0, 0});
    tbl.push_back('{1, 4'd5, 0, 4'd5, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd4, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd3, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd2, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd1, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd0, 0, 1});
    tbl.push_back('{1, 4'd0, 1, 4'd0, 0, 0});
    tbl.push_back('{1, 4'd3, 0, 4'd3, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd2, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 4'd2, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd1, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 4'd1, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd0, 0, 1});
    tbl.push_back('{1, 4'd4, 0, 4'd4, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd3, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd2, 1, 0});
    tbl.push_back('{1, 4'd9, 1, 4'd9, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd8, 1, 0});
    tbl.push_back('{1, 4'd0, 1, 4'd0, 0, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd0, 0, 0});
    tbl.push_back('{1, 4'd1, 0, 4'd1, 1, 0});
    tbl.push_back('{0, 4'd0, 1, 4'd0, 0, 1});
    tbl.push_back('{1, 4'd4, 1, 4'd4, 1, 0});
    tbl.push_back('{1, 4'd0, 0, 4'd0, 0, 0});

    foreach (tbl[i]) begin
      tick(tbl[i].ld, tbl[i].val, tbl[i].e);
      chk($sformatf("vec%0d.count", i), int'(count), int'(tbl[i].c));
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].b));
      chk($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].d));
    end

    // async reset mid-run with count=7: immediate clear, no done afterwards
    tick(1, 4'd7, 0);
    chk("rst_pre.count", int'(count), 7);
    tick(0, 4'd0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async.count", int'(count), 0);
    chk("rst_async.busy", int'(busy), 0);
    chk("rst_async.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 4'd0, 1);
      if (done) ndone++;
    end
    chk("rst_after.dones", ndone, 0);
    chk("rst_after.count", int'(count), 0);

    // full-range load: done exactly on the 15th enabled edge
    tick(1, 4'd15, 1);
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(0, 4'd0, 1);
      if (done) ndone++;
    end
    chk("max.early_done", ndone, 0);
    chk("max.count14", int'(count), 1);
    tick(0, 4'd0, 1);
    chk("max.done", int'(done), 1);
    chk("max.count", int'(count), 0);
    tick(1, 4'd0, 0);
    chk("max.stop", int'(busy), 0);

    // load 3 with en held: one-shot returns to idle, auto-reload repeats every 4 cycles
    if (AUTO) seq_exp = '{2, 1, 0, 3, 2, 1, 0, 3};
    else      seq_exp = '{2, 1, 0, 0, 0, 0, 0, 0};
    tick(1, 4'd3, 1);
    chk("period.load", int'(count), 3);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 4'd0, 1);
      chk($sformatf("period%0d.count", i), int'(count), seq_exp[i]);
      if (done) ndone++;
    end
    chk("period.dones", ndone, AUTO ? 2 : 1);
    tick(1, 4'd0, 0);
    chk("period.stop.busy", int'(busy), 0);
    chk_model("period.stop");

    // random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      bit          ld;
      logic [3:0]  v;
      bit          e;
      ld = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      e  = ($urandom_range(0, 3) != 0);
      tick(ld, v, e);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
